// File: rtl/lzw_io_pkg.sv
// Shared constants and types for the LZW I/O RAM stream reader.
// Optional feature macro used by io_ram_stream_rd: IO_RAM_STREAM_RD_SUM_EN.
package lzw_io_pkg;

    localparam int unsigned ADDR_W     = 12;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned LEN_W      = 13;
    localparam int unsigned SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    // Width of an occupancy counter able to hold 0..depth.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/io_rd_skid.sv
// Small synchronous FIFO that absorbs the RAM read latency ahead of the
// output stream. The head entry is a register, so pop_data has no path
// from push_data.
module io_rd_skid
    import lzw_io_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         empty,
    output logic [cnt_width(DEPTH)-1:0]  count
);

    localparam int unsigned CNT_W = cnt_width(DEPTH);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_MAX) ? '0 : p + PTR_W'(1);
    endfunction

    // Qualify push/pop so the FIFO can never over- or underflow.
    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count != CNT_FULL) || do_pop);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Head entry and empty flag.
    always_comb begin
        pop_data = mem[rd_ptr];
        empty    = (count == '0);
    end

endmodule

// File: rtl/io_ram_stream_rd.sv
// Read-side initiator for one port of the banked I/O byte RAM. Fetches a
// block of consecutive bytes and presents them as a valid/ready stream.
// Optional feature: define IO_RAM_STREAM_RD_SUM_EN to enable the rd_sum
// running checksum; otherwise rd_sum is tied to zero.
module io_ram_stream_rd #(
    parameter int unsigned ADDR_W     = lzw_io_pkg::ADDR_W,
    parameter int unsigned DATA_W     = lzw_io_pkg::DATA_W,
    parameter int unsigned LEN_W      = lzw_io_pkg::LEN_W,
    parameter int unsigned SKID_DEPTH = lzw_io_pkg::SKID_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              ram_en,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic [DATA_W-1:0] rd_sum
);

    import lzw_io_pkg::*;

    localparam int unsigned CNT_W = cnt_width(SKID_DEPTH);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(SKID_DEPTH);

    rd_state_t         state;
    rd_state_t         state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] last_addr;
    logic [LEN_W-1:0]  issue_rem;
    logic [LEN_W-1:0]  deliv_rem;
    logic              inflight;
    logic              done_r;
    logic [CNT_W-1:0]  occ;
    logic [CNT_W:0]    occ_after;
    logic              empty;
    logic              credit;
    logic              issue;
    logic              accept;
    logic              start_acc;

    io_rd_skid #(
        .DEPTH (SKID_DEPTH),
        .WIDTH (DATA_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (ram_rd_data),
        .pop       (accept),
        .pop_data  (out_data),
        .empty     (empty),
        .count     (occ)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && (length != '0)) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (issue && (issue_rem == LEN_W'(1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (accept && out_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs and issue credit. The byte leaving this cycle is counted as
    // freed so a new read can be issued behind it; without that the
    // stream could not sustain one byte per clock with a 2-entry buffer.
    always_comb begin
        busy      = (state != IDLE);
        start_acc = (state == IDLE) && start;
        out_valid = !empty;
        out_last  = out_valid && (deliv_rem == LEN_W'(1));
        accept    = out_valid && out_ready;
        occ_after = {1'b0, occ} + (CNT_W + 1)'(inflight) - (CNT_W + 1)'(accept);
        credit    = (occ_after < DEPTH_C);
        issue     = (state == RUN) && credit;
        ram_en    = issue;
        ram_wr    = 1'b0;
        ram_addr  = issue ? addr : last_addr;
        done      = done_r;
    end

    // Transfer datapath: address, remaining counts, in-flight flag, done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr      <= '0;
            last_addr <= '0;
            issue_rem <= '0;
            deliv_rem <= '0;
            inflight  <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r   <= 1'b0;
            inflight <= issue;
            if (start_acc) begin
                addr      <= base_addr;
                issue_rem <= length;
                deliv_rem <= length;
                done_r    <= (length == '0);
            end
            if (issue) begin
                last_addr <= addr;
                addr      <= addr + ADDR_W'(1);
                issue_rem <= issue_rem - LEN_W'(1);
            end
            if (accept) begin
                deliv_rem <= deliv_rem - LEN_W'(1);
                if (out_last) begin
                    done_r <= 1'b1;
                end
            end
        end
    end

`ifdef IO_RAM_STREAM_RD_SUM_EN
    logic [DATA_W-1:0] sum_r;

    // Modulo sum of accepted bytes, cleared by each accepted start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_r <= '0;
        end else if (start_acc) begin
            sum_r <= '0;
        end else if (accept) begin
            sum_r <= sum_r + out_data;
        end
    end

    assign rd_sum = sum_r;
`else
    assign rd_sum = '0;
`endif

endmodule

// File: tb/tb_io_ram_stream_rd.sv
// Self-checking bench for io_ram_stream_rd: behavioural RAM with one-cycle
// read latency, scoreboard of expected bytes/addresses per transfer.
module tb_io_ram_stream_rd;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] base_addr;
    logic [12:0] length;
    logic        busy, done, ram_en, ram_wr;
    logic [11:0] ram_addr;
    logic [7:0]  ram_rd_data;
    logic        out_valid, out_last, out_ready;
    logic [7:0]  out_data, rd_sum;

    logic [7:0] mem [4096];

    int checks = 0;
    int passed = 0;

    // scoreboard (pushed when stimulus is prepared)
    logic [7:0]  sb_d[$];
    logic        sb_l[$];
    logic [11:0] sb_a[$];

    // observations of the latest transfer
    logic [7:0]  got_d[$];
    logic        got_l[$];
    logic [11:0] addr_log[$];
    int first_en, first_valid, last_acc, done_cyc, done_cnt, max_out, valid_after_rst;
    logic busy_at1, busy_at_done, busy_any, en_any, timed_out;
    logic [7:0] sum_at_done, sum_after;
    logic [31:0] snap;

    io_ram_stream_rd #(
        .ADDR_W (12), .DATA_W (8), .LEN_W (13), .SKID_DEPTH (2)
    ) dut (
        .clk (clk), .rst_n (rst_n), .start (start), .base_addr (base_addr),
        .length (length), .busy (busy), .done (done), .ram_en (ram_en),
        .ram_wr (ram_wr), .ram_addr (ram_addr), .ram_rd_data (ram_rd_data),
        .out_valid (out_valid), .out_data (out_data), .out_last (out_last),
        .out_ready (out_ready), .rd_sum (rd_sum)
    );

    always #5 clk = ~clk;

    // RAM model: data valid the cycle after the enable
    always @(posedge clk) begin
        if (ram_en) ram_rd_data <= mem[ram_addr];
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic ready_fn(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (c >= 10 && c < 20) return 1'b0;
        return ((c % 3) == 0);
    endfunction

    function automatic logic [7:0] exp_sum();
        logic [7:0] s = '0;
`ifdef IO_RAM_STREAM_RD_SUM_EN
        foreach (sb_d[i]) s = s + sb_d[i];
`endif
        return s;
    endfunction

    task automatic load_xfer(input logic [11:0] base, input int len);
        logic [11:0] a;
        for (int i = 0; i < len; i++) begin
            a = base + 12'(i);
            mem[a] = 8'($urandom);
            sb_d.push_back(mem[a]);
            sb_l.push_back(i == len - 1);
            sb_a.push_back(a);
        end
    endtask

    task automatic sb_clear();
        sb_d.delete(); sb_l.delete(); sb_a.delete();
    endtask

    // Drive one start and run the stream, recording what the DUT does.
    task automatic run_xfer(input logic [11:0] base, input logic [12:0] len,
                            input int mode, input int inject_cyc, input int abort_after);
        int issued, acc, rst_cyc;
        logic fin;
        got_d.delete(); got_l.delete(); addr_log.delete();
        first_en = -1; first_valid = -1; last_acc = -1; done_cyc = -1;
        done_cnt = 0; max_out = 0; valid_after_rst = 0;
        busy_at1 = 0; busy_at_done = 1; busy_any = 0; en_any = 0;
        sum_at_done = 8'hxx; sum_after = 8'hxx; snap = 32'hffff_ffff;
        issued = 0; acc = 0; rst_cyc = -1; fin = 0;
        @(negedge clk);
        start = 1; base_addr = base; length = len; out_ready = ready_fn(mode, 0);
        for (int c = 0; c < 400; c++) begin
            #1;
            if (ram_en) begin
                addr_log.push_back(ram_addr); issued++; en_any = 1;
                if (first_en < 0) first_en = c;
            end
            if (busy) busy_any = 1;
            if (out_valid && first_valid < 0) first_valid = c;
            if (out_valid && out_ready && rst_cyc < 0) begin
                got_d.push_back(out_data); got_l.push_back(out_last); acc++;
                if (out_last) last_acc = c;
            end
            if (c == 1) busy_at1 = busy;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c; busy_at_done = busy; sum_at_done = rd_sum;
                end
            end
            if (done_cyc >= 0 && c == done_cyc + 1) sum_after = rd_sum;
            if (rst_cyc >= 0 && c == rst_cyc + 1)
                snap = {busy, done, ram_en, out_valid, out_last, ram_addr, out_data, rd_sum, 1'b0};
            if (rst_cyc >= 0 && c > rst_cyc && out_valid) valid_after_rst++;
            if (rst_cyc < 0 && issued - acc > max_out) max_out = issued - acc;
            if (done_cyc >= 0 && c >= done_cyc + 1) begin fin = 1; break; end
            if (rst_cyc >= 0 && c >= rst_cyc + 8) begin fin = 1; break; end
            @(negedge clk);
            start = 0; rst_n = 1; out_ready = ready_fn(mode, c + 1);
            if (c + 1 == inject_cyc) begin
                start = 1; base_addr = 12'h100; length = 13'd3;
            end
            if (abort_after > 0 && rst_cyc < 0 && acc >= abort_after) begin
                rst_n = 0; rst_cyc = c + 1;
            end
        end
        timed_out = !fin;
        start = 0; rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; start = 0; out_ready = 0; base_addr = '0; length = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, ram_en, out_valid, out_last, ram_addr, out_data, rd_sum} !== '0)
            $display("FAIL reset_outputs: got %h required 0",
                     {busy, done, ram_en, out_valid, out_last, ram_addr, out_data, rd_sum});
        else passed++;
        checks++;
        if (ram_wr !== 1'b0) $display("FAIL reset_ram_wr: got %b required 0", ram_wr);
        else passed++;
        rst_n = 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] es;
        sb_clear();
        for (int i = 0; i < 5; i++) begin
            mem[12'h010 + 12'(i)] = 8'hA0 + 8'(i);
            sb_d.push_back(8'hA0 + 8'(i)); sb_l.push_back(i == 4);
        end
        es = exp_sum();
        run_xfer(12'h010, 13'd5, 0, -1, 0);
        checks++;
        if (timed_out) $display("FAIL basic_timeout: no done within budget"); else passed++;
        checks++;
        if (first_en !== 1) $display("FAIL basic_first_en: got cycle %0d required 1", first_en); else passed++;
        checks++;
        if (busy_at1 !== 1'b1) $display("FAIL basic_busy: got %b required 1", busy_at1); else passed++;
        checks++;
        if (first_valid !== 3) $display("FAIL basic_first_valid: got cycle %0d required 3", first_valid); else passed++;
        checks++;
        if (got_d.size() !== 5) $display("FAIL basic_count: got %0d required 5", got_d.size());
        else begin
            passed++;
            for (int i = 0; i < 5; i++) begin
                checks++;
                if ({got_d[i], got_l[i]} !== {sb_d[0], sb_l[0]})
                    $display("FAIL basic_byte%0d: got %h/%b required %h/%b", i, got_d[i], got_l[i], sb_d[0], sb_l[0]);
                else passed++;
                void'(sb_d.pop_front()); void'(sb_l.pop_front());
            end
        end
        checks++;
        if (last_acc !== 7) $display("FAIL basic_last_cycle: got %0d required 7", last_acc); else passed++;
        checks++;
        if (done_cyc !== last_acc + 1 || done_cnt !== 1)
            $display("FAIL basic_done: got cycle %0d count %0d required %0d/1", done_cyc, done_cnt, last_acc + 1);
        else passed++;
        checks++;
        if (busy_at_done !== 1'b0) $display("FAIL basic_busy_at_done: got %b required 0", busy_at_done); else passed++;
        checks++;
        if (sum_at_done !== es || sum_after !== es)
            $display("FAIL basic_rd_sum: got %h then %h required %h", sum_at_done, sum_after, es);
        else passed++;
    endtask

    task automatic test_wrap();
        sb_clear();
        load_xfer(12'hFFE, 4);
        run_xfer(12'hFFE, 13'd4, 0, -1, 0);
        checks++;
        if (timed_out || addr_log.size() !== 4)
            $display("FAIL wrap_addr_count: got %0d required 4 (timeout %b)", addr_log.size(), timed_out);
        else begin
            passed++;
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (addr_log[i] !== sb_a[i] || got_d[i] !== sb_d[i])
                    $display("FAIL wrap_%0d: got addr %h data %h required %h/%h", i, addr_log[i], got_d[i], sb_a[i], sb_d[i]);
                else passed++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] es;
        sb_clear();
        load_xfer(12'h200, 8);
        es = exp_sum();
        run_xfer(12'h200, 13'd8, 1, -1, 0);
        checks++;
        if (timed_out || got_d.size() !== 8)
            $display("FAIL bp_count: got %0d required 8 (timeout %b)", got_d.size(), timed_out);
        else begin
            passed++;
            for (int i = 0; i < 8; i++) begin
                checks++;
                if ({got_d[i], got_l[i]} !== {sb_d[i], sb_l[i]})
                    $display("FAIL bp_byte%0d: got %h/%b required %h/%b", i, got_d[i], got_l[i], sb_d[i], sb_l[i]);
                else passed++;
            end
        end
        checks++;
        if (max_out > 2) $display("FAIL bp_outstanding: got %0d required <=2", max_out); else passed++;
        checks++;
        if (done_cnt !== 1 || sum_at_done !== es)
            $display("FAIL bp_done_sum: got done %0d sum %h required 1/%h", done_cnt, sum_at_done, es);
        else passed++;
    endtask

    task automatic test_zero_length();
        run_xfer(12'h055, 13'd0, 0, -1, 0);
        checks++;
        if (done_cyc !== 1 || done_cnt !== 1)
            $display("FAIL zero_done: got cycle %0d count %0d required 1/1", done_cyc, done_cnt);
        else passed++;
        checks++;
        if (busy_any !== 1'b0 || en_any !== 1'b0)
            $display("FAIL zero_idle: got busy %b ram_en %b required 0/0", busy_any, en_any);
        else passed++;
    endtask

    task automatic test_start_while_busy();
        sb_clear();
        load_xfer(12'h040, 5);
        run_xfer(12'h040, 13'd5, 0, 4, 0);
        checks++;
        if (timed_out || addr_log.size() !== 5 || got_d.size() !== 5)
            $display("FAIL busy_start_count: got %0d issues %0d bytes required 5/5", addr_log.size(), got_d.size());
        else begin
            passed++;
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (addr_log[i] !== sb_a[i] || {got_d[i], got_l[i]} !== {sb_d[i], sb_l[i]})
                    $display("FAIL busy_start_%0d: got %h %h/%b required %h %h/%b",
                             i, addr_log[i], got_d[i], got_l[i], sb_a[i], sb_d[i], sb_l[i]);
                else passed++;
            end
        end
        checks++;
        if (done_cnt !== 1) $display("FAIL busy_start_done: got %0d required 1", done_cnt); else passed++;
    endtask

    task automatic test_reset_mid();
        sb_clear();
        load_xfer(12'h300, 10);
        run_xfer(12'h300, 13'd10, 0, -1, 3);
        checks++;
        if (snap !== '0) $display("FAIL rst_mid_outputs: got %h required 0", snap); else passed++;
        checks++;
        if (done_cnt !== 0 || valid_after_rst !== 0)
            $display("FAIL rst_mid_quiet: got done %0d valid %0d required 0/0", done_cnt, valid_after_rst);
        else passed++;
        sb_clear();
        load_xfer(12'h3F0, 2);
        run_xfer(12'h3F0, 13'd2, 0, -1, 0);
        checks++;
        if (timed_out || got_d.size() !== 2 || done_cnt !== 1)
            $display("FAIL rst_mid_after: got %0d bytes done %0d required 2/1", got_d.size(), done_cnt);
        else if ({got_d[0], got_l[0], got_d[1], got_l[1]} !== {sb_d[0], sb_l[0], sb_d[1], sb_l[1]})
            $display("FAIL rst_mid_after_data: got %h %h required %h %h", got_d[0], got_d[1], sb_d[0], sb_d[1]);
        else passed++;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        ram_rd_data = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_length();
        test_start_while_busy();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
